// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: opcodes, ALU codes,
// mux select encodings, FSM states and the per-state Moore control word.
package riscv_pkg;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
        StExecR, StExecI, StAluWb, StBeq, StJal
    } state_e;

    typedef enum logic [1:0] {ResAluOut = 2'b00, ResData = 2'b01, ResAluResult = 2'b10} result_src_e;
    typedef enum logic [1:0] {SrcAPc = 2'b00, SrcAOldPc = 2'b01, SrcARs1 = 2'b10} src_a_e;
    typedef enum logic [1:0] {SrcBRs2 = 2'b00, SrcBImm = 2'b01, SrcBFour = 2'b10} src_b_e;
    typedef enum logic [1:0] {ImmI = 2'b00, ImmS = 2'b01, ImmB = 2'b10, ImmJ = 2'b11} imm_src_e;
    typedef enum logic [1:0] {AluOpAdd = 2'b00, AluOpSub = 2'b01, AluOpFunct = 2'b10} alu_op_e;

    typedef struct packed {
        logic        adr_src;
        result_src_e result_src;
        src_a_e      alu_src_a;
        src_b_e      alu_src_b;
        alu_op_e     alu_op;
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        pc_update;
        logic        fetch;
    } ctrl_t;

    // Moore control word for a state; unlisted fields stay at their zero encoding.
    function automatic ctrl_t state_ctrl(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch: begin
                c.alu_src_b  = SrcBFour;
                c.result_src = ResAluResult;
                c.fetch      = 1'b1;
            end
            StDecode: begin
                c.alu_src_a = SrcAOldPc;
                c.alu_src_b = SrcBImm;
            end
            StMemAdr: begin
                c.alu_src_a = SrcARs1;
                c.alu_src_b = SrcBImm;
            end
            StMemRead:  c.adr_src = 1'b1;
            StMemWb: begin
                c.result_src = ResData;
                c.reg_write  = 1'b1;
            end
            StMemWrite: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            StExecR: begin
                c.alu_src_a = SrcARs1;
                c.alu_op    = AluOpFunct;
            end
            StExecI: begin
                c.alu_src_a = SrcARs1;
                c.alu_src_b = SrcBImm;
                c.alu_op    = AluOpFunct;
            end
            StAluWb:    c.reg_write = 1'b1;
            StBeq: begin
                c.alu_src_a = SrcARs1;
                c.alu_op    = AluOpSub;
                c.branch    = 1'b1;
            end
            StJal: begin
                c.alu_src_a = SrcAOldPc;
                c.alu_src_b = SrcBFour;
                c.pc_update = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle: instruction fields and flags in, enables and selects out.
interface multicycle_control_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [2:0] alu_control;
    logic       illegal_instr;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
               imm_src, reg_write, alu_control, illegal_instr
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
               imm_src, reg_write, alu_control, illegal_instr
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: maps the FSM's ALU-op class plus instruction fields to the 3-bit ALU code.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  alu_op_e    alu_op,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = AluAdd;
        case (alu_op)
            AluOpSub:   alu_control = AluSub;
            AluOpFunct: begin
                case (funct3)
                    // Only R-type (op[5]=1) subtracts; addi ignores instr[30].
                    3'b000:  alu_control = (op5 && funct7b5) ? AluSub : AluAdd;
                    3'b010:  alu_control = AluSlt;
                    3'b110:  alu_control = AluOr;
                    3'b111:  alu_control = AluAnd;
                    default: alu_control = AluAdd;
                endcase
            end
            default:    alu_control = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: Moore sequencing FSM with registered control word,
// memory-ready stalls and an illegal-instruction pulse in DECODE.
module multicycle_control
    import riscv_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input logic                   clk,
    input logic                   rst_n,
    multicycle_control_if.master  bus
);

    state_e     state_q, state_d;
    ctrl_t      ctrl_q;
    logic       mem_ready;
    logic       legal;
    logic       fetch_go;
    imm_src_e   imm_src;
    logic [2:0] alu_control;

    assign mem_ready = MEM_WAIT_EN ? bus.mem_ready : 1'b1;

    always_comb begin
        legal = 1'b0;
        case (bus.op)
            OpLoad, OpStore:  legal = (bus.funct3 == 3'b010);
            OpRtype, OpItype: legal = bus.funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
            OpBranch:         legal = (bus.funct3 == 3'b000);
            OpJal:            legal = 1'b1;
            default:          legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:    state_d = mem_ready ? StDecode : StFetch;
            StDecode: begin
                if (legal) begin
                    case (bus.op)
                        OpLoad, OpStore: state_d = StMemAdr;
                        OpRtype:         state_d = StExecR;
                        OpItype:         state_d = StExecI;
                        OpBranch:        state_d = StBeq;
                        OpJal:           state_d = StJal;
                        default:         state_d = StFetch;
                    endcase
                end
            end
            StMemAdr:   state_d = (bus.op == OpStore) ? StMemWrite : StMemRead;
            StMemRead:  state_d = mem_ready ? StMemWb : StMemRead;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = mem_ready ? StFetch : StMemWrite;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
            StJal:      state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    // Control word is registered alongside the state so outputs are glitch-free Moore values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            ctrl_q  <= state_ctrl(StFetch);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
        end
    end

    always_comb begin
        case (bus.op)
            OpStore:  imm_src = ImmS;
            OpBranch: imm_src = ImmB;
            OpJal:    imm_src = ImmJ;
            default:  imm_src = ImmI;
        endcase
    end

    alu_decoder u_alu_decoder (
        .op5         (bus.op[5]),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .alu_op      (ctrl_q.alu_op),
        .alu_control (alu_control)
    );

    // The FETCH strobes depend on mem_ready, so they are masked while reset is held.
    assign fetch_go = ctrl_q.fetch & mem_ready & rst_n;

    assign bus.pc_write      = ctrl_q.pc_update | fetch_go | (ctrl_q.branch & bus.zero);
    assign bus.ir_write      = fetch_go;
    assign bus.adr_src       = ctrl_q.adr_src;
    assign bus.mem_write     = ctrl_q.mem_write;
    assign bus.reg_write     = ctrl_q.reg_write;
    assign bus.result_src    = ctrl_q.result_src;
    assign bus.alu_src_a     = ctrl_q.alu_src_a;
    assign bus.alu_src_b     = ctrl_q.alu_src_b;
    assign bus.imm_src       = imm_src;
    assign bus.alu_control   = alu_control;
    assign bus.illegal_instr = (state_q == StDecode) & ~legal;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into the phase list the ISA
// implies and every cycle's outputs are compared against values derived from that list.
module tb_multicycle_control;

    localparam int PhFetch = 0, PhDecode = 1, PhAddr = 2, PhRead = 3, PhLoadWb = 4, PhWrite = 5;
    localparam int PhExecR = 6, PhExecI = 7, PhWb = 8, PhBeq = 9, PhJal = 10;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail = 0;
    int phases[$];

    function automatic logic [16:0] observed();
        return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
                bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.reg_write, bus.alu_control,
                bus.illegal_instr};
    endfunction

    function automatic bit ref_legal(logic [6:0] op, logic [2:0] f3);
        if (op == LW || op == SW) return f3 == 3'd2;
        if (op == RT || op == IT) return f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7;
        if (op == BQ) return f3 == 3'd0;
        return op == JL;
    endfunction

    function automatic int ref_imm(logic [6:0] op);
        if (op == SW) return 1;
        if (op == BQ) return 2;
        if (op == JL) return 3;
        return 0;
    endfunction

    // add 010, sub 110, and 000, or 001, slt 111
    function automatic int ref_alu(logic [6:0] op, logic [2:0] f3, logic f7);
        if (f3 == 3'd2) return 7;
        if (f3 == 3'd6) return 1;
        if (f3 == 3'd7) return 0;
        if (f3 == 3'd0 && op == RT && f7) return 6;
        return 2;
    endfunction

    function automatic void plan(logic [6:0] op, logic [2:0] f3);
        phases.delete();
        phases.push_back(PhFetch);
        phases.push_back(PhDecode);
        if (!ref_legal(op, f3)) return;
        if (op == LW) begin phases.push_back(PhAddr); phases.push_back(PhRead); phases.push_back(PhLoadWb); end
        if (op == SW) begin phases.push_back(PhAddr); phases.push_back(PhWrite); end
        if (op == RT) begin phases.push_back(PhExecR); phases.push_back(PhWb); end
        if (op == IT) begin phases.push_back(PhExecI); phases.push_back(PhWb); end
        if (op == BQ) phases.push_back(PhBeq);
        if (op == JL) begin phases.push_back(PhJal); phases.push_back(PhWb); end
    endfunction

    // Field order: pcw adr mw irw rs a b imm rw alu ill; -1 marks a don't-care field.
    function automatic void expect_of(input int ph, input logic mr, input logic z,
                                      input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                      output logic [16:0] e, output logic [16:0] c);
        int v[11];
        int w[11];
        w = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 3, 1};
        v = '{0, -1, 0, 0, -1, -1, -1, ref_imm(op), 0, -1, 0};
        case (ph)
            PhFetch:  begin v[0] = int'(mr); v[1] = 0; v[3] = int'(mr); v[4] = 2; v[5] = 0; v[6] = 2; v[9] = 2; end
            PhDecode: begin v[5] = 1; v[6] = 1; v[9] = 2; v[10] = ref_legal(op, f3) ? 0 : 1; end
            PhAddr:   begin v[5] = 2; v[6] = 1; v[9] = 2; end
            PhRead:   begin v[1] = 1; v[4] = 0; end
            PhLoadWb: begin v[4] = 1; v[8] = 1; end
            PhWrite:  begin v[1] = 1; v[4] = 0; v[2] = 1; end
            PhExecR:  begin v[5] = 2; v[6] = 0; v[9] = ref_alu(op, f3, f7); end
            PhExecI:  begin v[5] = 2; v[6] = 1; v[9] = ref_alu(op, f3, f7); end
            PhWb:     begin v[4] = 0; v[8] = 1; end
            PhBeq:    begin v[0] = int'(z); v[5] = 2; v[6] = 0; v[9] = 6; v[4] = 0; end
            PhJal:    begin v[0] = 1; v[5] = 1; v[6] = 2; v[9] = 2; v[4] = 0; end
            default:  ;
        endcase
        e = '0;
        c = '0;
        for (int i = 0; i < 11; i++) begin
            e = (e << w[i]) | ((v[i] < 0) ? 17'd0 : 17'(v[i]));
            c = (c << w[i]) | ((v[i] < 0) ? 17'd0 : 17'((1 << w[i]) - 1));
        end
    endfunction

    // Runs one instruction from FETCH; stall counts of -1 are randomised, force_zero -1 random.
    task automatic drive_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                               input logic f7, input int fetch_stalls, input int mem_stalls,
                               input int force_zero, output int cycles);
        logic [16:0] e, c, o;
        plan(op, f3);
        cycles = 0;
        bus.op = op;
        bus.funct3 = f3;
        bus.funct7b5 = f7;
        foreach (phases[k]) begin
            int ph, stalls;
            bit is_mem;
            ph = phases[k];
            is_mem = (ph == PhFetch || ph == PhRead || ph == PhWrite);
            stalls = 0;
            if (is_mem) begin
                stalls = (ph == PhFetch) ? fetch_stalls : mem_stalls;
                if (stalls < 0) stalls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            end
            for (int s = 0; s <= stalls; s++) begin
                bus.mem_ready = is_mem ? (s == stalls) : 1'($urandom);
                bus.zero = (force_zero < 0) ? 1'($urandom) : 1'(force_zero);
                @(negedge clk);
                expect_of(ph, bus.mem_ready, bus.zero, op, f3, f7, e, c);
                o = observed();
                n_tests++;
                if (((o ^ e) & c) != 17'd0) begin
                    n_fail++;
                    $display("FAIL %s phase=%0d cycle=%0d: got %b required %b (care %b)",
                             name, ph, cycles, o, e, c);
                end
                cycles++;
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        logic [16:0] e, c, o;
        int cyc;
        rst_n = 1'b0;
        bus.op = RT;
        bus.funct3 = 3'd0;
        bus.funct7b5 = 1'b1;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            expect_of(PhFetch, 1'b0, 1'b0, RT, 3'd0, 1'b1, e, c);
            o = observed();
            n_tests++;
            if (((o ^ e) & c) != 17'd0) begin
                n_fail++;
                $display("FAIL reset_hold: got %b required %b (care %b)", o, e, c);
            end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive_instr("reset_sub", RT, 3'd0, 1'b1, 0, 0, -1, cyc);
        n_tests++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL reset_sub_latency: got %0d required 4", cyc);
        end
    endtask

    task automatic test_lw_stall();
        int cyc;
        drive_instr("lw_stall", LW, 3'd2, 1'b0, 0, 2, -1, cyc);
        n_tests++;
        if (cyc !== 7) begin
            n_fail++;
            $display("FAIL lw_stall_latency: got %0d required 7", cyc);
        end
    endtask

    task automatic test_sw();
        int cyc;
        drive_instr("sw", SW, 3'd2, 1'b1, 0, 0, -1, cyc);
        n_tests++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL sw_latency: got %0d required 4", cyc);
        end
    endtask

    task automatic test_beq();
        int cyc;
        for (int z = 0; z < 2; z++) begin
            drive_instr(z ? "beq_taken" : "beq_not_taken", BQ, 3'd0, 1'b0, 0, 0, z, cyc);
            n_tests++;
            if (cyc !== 3) begin
                n_fail++;
                $display("FAIL beq_latency: got %0d required 3", cyc);
            end
        end
    endtask

    task automatic test_alu_imm();
        int cyc;
        logic [2:0] f3s[4];
        f3s = '{3'd0, 3'd2, 3'd6, 3'd7};
        foreach (f3s[i]) begin
            drive_instr("alu_imm", IT, f3s[i], 1'b1, 0, 0, -1, cyc);
            n_tests++;
            if (cyc !== 4) begin
                n_fail++;
                $display("FAIL alu_imm_latency f3=%0d: got %0d required 4", f3s[i], cyc);
            end
        end
        drive_instr("jal", JL, 3'd5, 1'b0, 0, 0, -1, cyc);
        n_tests++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL jal_latency: got %0d required 4", cyc);
        end
    endtask

    task automatic test_illegal();
        int cyc;
        drive_instr("illegal_op", 7'h7f, 3'd0, 1'b0, 0, 0, -1, cyc);
        drive_instr("illegal_lw_f3", LW, 3'd0, 1'b0, 0, 0, -1, cyc);
        drive_instr("after_illegal", RT, 3'd7, 1'b0, 0, 0, -1, cyc);
        n_tests++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL after_illegal_latency: got %0d required 4", cyc);
        end
    endtask

    task automatic test_reset_in_memwrite();
        int cyc;
        bus.op = SW;
        bus.funct3 = 3'd2;
        bus.funct7b5 = 1'b0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (bus.mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL memwrite_before_reset: got %b required 1", bus.mem_write);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.mem_write, bus.reg_write, bus.ir_write, bus.pc_write} !== 4'b0000) begin
            n_fail++;
            $display("FAIL memwrite_async_reset: got %b required 0000",
                     {bus.mem_write, bus.reg_write, bus.ir_write, bus.pc_write});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive_instr("after_reset", RT, 3'd6, 1'b0, 0, 0, -1, cyc);
    endtask

    task automatic test_random();
        int cyc;
        logic [6:0] op;
        logic [2:0] f3;
        logic [2:0] alu_f3[4];
        logic [6:0] legal_ops[6];
        alu_f3 = '{3'd0, 3'd2, 3'd6, 3'd7};
        legal_ops = '{LW, SW, RT, IT, BQ, JL};
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 7))
                0: begin op = LW; f3 = 3'd2; end
                1: begin op = SW; f3 = 3'd2; end
                2: begin op = RT; f3 = alu_f3[$urandom_range(0, 3)]; end
                3: begin op = IT; f3 = alu_f3[$urandom_range(0, 3)]; end
                4: begin op = BQ; f3 = 3'd0; end
                5: begin op = JL; f3 = 3'($urandom); end
                6: begin
                    op = 7'($urandom);
                    for (int t = 0; t < 8 && op inside {LW, SW, RT, IT, BQ, JL}; t++) op = 7'($urandom);
                    if (op inside {LW, SW, RT, IT, BQ, JL}) op = 7'h7f;
                    f3 = 3'($urandom);
                end
                default: begin op = legal_ops[$urandom_range(0, 5)]; f3 = 3'($urandom); end
            endcase
            drive_instr("random", op, f3, 1'($urandom), -1, -1, -1, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_lw_stall();
        test_sw();
        test_beq();
        test_alu_imm();
        test_illegal();
        test_reset_in_memwrite();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control unit for the multicycle RISC-V datapath; it is the producer of the ALU's 3-bit control code and mux selects.
- Moore FSM for sequencing plus a combinational ALU decoder driving alu_control (ADD 010, SUB 110, AND 000, OR 001, SLT 111).
- Adds a mem_ready stall so fetch, load and store wait on the shared memory.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal.

Parameters:
- MEM_WAIT_EN, 1, when 0 the mem_ready input is ignored and treated as 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  7  opcode from instruction register.
- funct3  in  3  from instruction register.
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  PC enable.
- adr_src  out  1  0 = PC, 1 = ALUOut.
- mem_write  out  1  store strobe.
- ir_write  out  1  IR/oldPC enable.
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALU result.
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- reg_write  out  1  register file write enable.
- alu_control  out  3  ALU operation.
- illegal_instr  out  1  one-cycle pulse on an unsupported instruction.

Behaviour:
- Reset: async to FETCH. While rst_n=0, pc_write, ir_write, mem_write, reg_write and illegal_instr are 0; other outputs take FETCH values.
- Moore outputs come from state. alu_control is combinational from state, op, funct3 and funct7b5.
- pc_write = pc_update | (branch & zero). It uses same-cycle zero.
- FETCH:
  - adr_src=0, a=00, b=10, ADD, result_src=10.
  - ir_write=pc_update=mem_ready.
  - Stays in FETCH while mem_ready=0. Goes to DECODE when mem_ready=1.
- DECODE:
  - a=01, b=01, ADD (branch target into ALUOut).
  - Next state by op: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL.
  - Any other op, or funct3 outside {000,010,110,111} for R/I, or funct3≠010 for lw/sw, or ≠000 for beq: illegal_instr=1 for this cycle, then → FETCH.
- MEMADR: a=10, b=01, ADD. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adr_src=1, result_src=00. Holds until mem_ready, then → MEMWB.
- MEMWB: result_src=01, reg_write=1, → FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 held until mem_ready, then → FETCH.
- EXECR: a=10, b=00, → ALUWB.
- EXECI: a=10, b=01, → ALUWB.
- ALUWB: result_src=00, reg_write=1, → FETCH.
- BEQ: a=10, b=00, SUB, result_src=00, branch=1, → FETCH.
- JAL: a=01, b=10, ADD, result_src=00, pc_update=1, reg_write=0, → ALUWB (rd ← oldPC+4).
- ALU decode in EXECR/EXECI: funct3 000 → SUB if op[5]&funct7b5, else ADD; 010 → SLT; 110 → OR; 111 → AND. All other states use the fixed code listed above.
- imm_src is combinational from op in every state: lw/addi-class → 00, sw → 01, beq → 10, jal → 11, others → 00.
- Latency with mem_ready=1 (cycles): lw 5, sw 4, R/I 4, beq 3, jal 4. Each memory stall adds 1 cycle per mem_ready=0 cycle.
- The FSM never enters an undefined state; any unreachable encoding → FETCH.
- Reset asserted mid-instruction aborts it; no partial write is issued after reset.

Decomposition:
- Package riscv_pkg:
  - ALU codes (ADD 010, SUB 110, AND 000, OR 001, SLT 111).
  - Opcode constants.
  - State enum.
  - result_src, alu_src_a, alu_src_b and imm_src encodings.
- Sub-module alu_decoder: combinational; inputs op[5], funct3, funct7b5 and a 2-bit alu_op class (00 ADD, 01 SUB, 10 funct-decoded); output alu_control.

Test Plan:
- Reset: hold rst_n=0, then release with mem_ready=1, op=0110011, funct3=000, funct7b5=1 → states FETCH, DECODE, EXECR, ALUWB. alu_control=110 in EXECR; reg_write=1 only in ALUWB.
- lw with mem_ready low for 2 cycles in MEMREAD → adr_src=1 held for 3 cycles, MEMWB reg_write=1, result_src=01. Total 7 cycles.
- sw → mem_write=1 exactly in MEMWRITE, imm_src=01, reg_write never asserted. Total 4 cycles.
- beq, once with zero=1 and once with zero=0 in the BEQ state → pc_write=1 vs 0 in that cycle. alu_control=110 and imm_src=10 in both.
- addi with funct7b5=1 (op 0010011, funct3 000) → alu_control=010, not SUB. slti (funct3 010) → 111; ori → 001; andi → 000.
- Illegal: op=1111111 → illegal_instr pulses 1 cycle in DECODE, next state FETCH, no write enables.
- Also: rst_n dropped during MEMWRITE → mem_write goes 0 immediately (async).
